// File: rtl/stack_arbiter_pkg.sv
// Shared types and defaults for the stack arbiter.
// Opcodes, parameter defaults and the response tag.
package stack_arbiter_pkg;

  localparam logic OP_PUSH = 1'b0;
  localparam logic OP_POP  = 1'b1;

  localparam int WIDTH_DEF   = 8;
  localparam int DEPTH_DEF   = 15;
  localparam int STK_LAT_DEF = 2;

  typedef struct packed {
    logic valid;
    logic id;
    logic op;
    logic err;
  } tag_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-input round-robin arbiter.
// The pointer always moves to the requester that lost.
module rr_arbiter2 (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] valid,
  output logic [1:0] grant
);

  logic prio;

  always_comb begin
    grant = 2'b00;
    if (!reset) begin
      if (&valid)
        grant = prio ? 2'b10 : 2'b01;
      else
        grant = valid;
    end
  end

  always_ff @(posedge clk) begin
    if (reset)
      prio <= 1'b0;
    else if (|grant)
      prio <= grant[0];
  end

endmodule

// File: rtl/stack_arbiter.sv
// Two-port push/pop sequencer for the 16-entry LIFO stack.
// Occupancy is committed at grant; results return in order.
module stack_arbiter
  import stack_arbiter_pkg::*;
#(
  parameter int WIDTH   = WIDTH_DEF,
  parameter int DEPTH   = DEPTH_DEF,
  parameter int STK_LAT = STK_LAT_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       req_valid,
  input  logic [1:0]       req_op,
  input  logic [2*WIDTH-1:0] req_data,
  output logic [1:0]       req_ready,
  output logic [1:0]       rsp_valid,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_err,
  output logic             stk_push,
  output logic             stk_pop,
  output logic [WIDTH-1:0] stk_data_in,
  input  logic [WIDTH-1:0] stk_data_out,
  output logic [4:0]       count,
  output logic             full,
  output logic             empty
);

  localparam logic [4:0] DEPTH_C = 5'(DEPTH);

  logic [1:0]       grant;
  logic             acc;
  logic             sel;
  logic             op;
  logic [WIDTH-1:0] data;
  logic             do_push;
  logic             do_pop;
  tag_t             tag_in;
  tag_t             tags [STK_LAT+1];
  tag_t             last;

  rr_arbiter2 u_arb (
    .clk   (clk),
    .reset (reset),
    .valid (req_valid),
    .grant (grant)
  );

  assign req_ready = grant;
  assign acc  = |grant;
  assign sel  = grant[1];
  assign op   = sel ? req_op[1] : req_op[0];
  assign data = sel ? req_data[2*WIDTH-1:WIDTH]
                    : req_data[WIDTH-1:0];

  assign do_push = acc && op == OP_PUSH && count != DEPTH_C;
  assign do_pop  = acc && op == OP_POP && count != 5'd0;

  always_comb begin
    tag_in.valid = acc;
    tag_in.id    = sel;
    tag_in.op    = op;
    tag_in.err   = acc && !(do_push || do_pop);
  end

  assign last  = tags[STK_LAT];
  assign full  = count == DEPTH_C;
  assign empty = count == 5'd0;

  always_ff @(posedge clk) begin
    if (reset) begin
      count       <= '0;
      stk_push    <= 1'b0;
      stk_pop     <= 1'b0;
      stk_data_in <= '0;
      rsp_valid   <= 2'b00;
      rsp_data    <= '0;
      rsp_err     <= 1'b0;
      for (int i = 0; i <= STK_LAT; i++)
        tags[i] <= '0;
    end else begin
      stk_push <= do_push;
      stk_pop  <= do_pop;
      if (do_push)
        stk_data_in <= data;
      if (do_push)
        count <= count + 5'd1;
      else if (do_pop)
        count <= count - 5'd1;
      tags[0] <= tag_in;
      for (int i = 1; i <= STK_LAT; i++)
        tags[i] <= tags[i-1];
      // Last stage lines up with the popped data on stk_data_out.
      rsp_valid <= !last.valid ? 2'b00 :
                   last.id ? 2'b10 : 2'b01;
      rsp_err   <= last.valid && last.err;
      rsp_data  <= (last.valid && last.op == OP_POP && !last.err)
                   ? stk_data_out : '0;
    end
  end

endmodule

// File: tb/tb_stack_arbiter.sv
// Randomized and directed bench for stack_arbiter.
// A queue-based LIFO model predicts grants and responses.
module tb_stack_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  req_valid = '0;
  logic [1:0]  req_op = '0;
  logic [15:0] req_data = '0;
  logic [1:0]  req_ready;
  logic [1:0]  rsp_valid;
  logic [7:0]  rsp_data;
  logic        rsp_err;
  logic        stk_push;
  logic        stk_pop;
  logic [7:0]  stk_data_in;
  logic [7:0]  stk_data_out;
  logic [4:0]  count;
  logic        full;
  logic        empty;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always #5 clk = ~clk;

  stack_arbiter dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_op       (req_op),
    .req_data     (req_data),
    .req_ready    (req_ready),
    .rsp_valid    (rsp_valid),
    .rsp_data     (rsp_data),
    .rsp_err      (rsp_err),
    .stk_push     (stk_push),
    .stk_pop      (stk_pop),
    .stk_data_in  (stk_data_in),
    .stk_data_out (stk_data_out),
    .count        (count),
    .full         (full),
    .empty        (empty)
  );

  // Attached stack: popped data valid two cycles after stk_pop.
  logic [7:0] env_stk [$];
  logic [7:0] d1 = '0;
  logic [7:0] d2 = '0;
  assign stk_data_out = d2;

  always @(posedge clk) begin
    if (reset) begin
      env_stk.delete();
    end else if (stk_push) begin
      env_stk.push_back(stk_data_in);
    end else if (stk_pop && env_stk.size() > 0) begin
      d1 <= env_stk.pop_back();
    end
    d2 <= d1;
  end

  typedef struct {
    int         due;
    logic [1:0] vld;
    logic [7:0] data;
    logic       err;
  } exp_t;

  exp_t       exp_q [$];
  logic [7:0] mstk [$];
  logic       mprio = 1'b0;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h @cyc %0d",
               tag, got, exp, cyc);
    end
  endtask

  task automatic step(input logic [1:0] v,
                      input logic [1:0] op,
                      input logic [7:0] d0,
                      input logic [7:0] d1i);
    logic [1:0] g;
    logic       id;
    logic [7:0] d;
    logic       e_push;
    logic       e_pop;
    logic [7:0] e_din;
    exp_t       e;
    @(negedge clk);
    req_valid = v;
    req_op    = op;
    req_data  = {d1i, d0};
    #1;
    g = (v == 2'b11) ? (mprio ? 2'b10 : 2'b01) : v;
    check("req_ready", req_ready, g);
    check("ready_onehot", req_ready == 2'b11, 0);
    e_push = 0;
    e_pop  = 0;
    e_din  = '0;
    if (g != 2'b00) begin
      id    = g[1];
      mprio = ~id;
      d     = id ? d1i : d0;
      e.due  = cyc + 4;
      e.vld  = g;
      e.data = '0;
      e.err  = 1'b0;
      if (op[id] == 1'b0) begin
        if (mstk.size() < 15) begin
          mstk.push_back(d);
          e_push = 1;
          e_din  = d;
        end else e.err = 1'b1;
      end else begin
        if (mstk.size() > 0) begin
          e.data = mstk.pop_back();
          e_pop  = 1;
        end else e.err = 1'b1;
      end
      exp_q.push_back(e);
    end
    @(posedge clk);
    cyc++;
    #1;
    check("stk_push", stk_push, e_push);
    check("stk_pop", stk_pop, e_pop);
    if (e_push) check("stk_data_in", stk_data_in, e_din);
    check("count", count, mstk.size());
    check("full", full, mstk.size() == 15);
    check("empty", empty, mstk.size() == 0);
    if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
      check("rsp_valid", rsp_valid, exp_q[0].vld);
      check("rsp_data", rsp_data, exp_q[0].data);
      check("rsp_err", rsp_err, exp_q[0].err);
      void'(exp_q.pop_front());
    end else begin
      check("rsp_idle", rsp_valid, 0);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++)
      step(2'b00, 2'b00, 8'h00, 8'h00);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset     = 1'b1;
    req_valid = 2'b11;
    #1;
    check("ready_in_reset", req_ready, 0);
    @(posedge clk);
    #1;
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_data", rsp_data, 0);
    check("rst_rsp_err", rsp_err, 0);
    check("rst_stk_cmd", {stk_push, stk_pop}, 0);
    check("rst_stk_din", stk_data_in, 0);
    check("rst_count", count, 0);
    check("rst_empty", empty, 1);
    @(posedge clk);
    @(negedge clk);
    reset     = 1'b0;
    req_valid = 2'b00;
    exp_q.delete();
    mstk.delete();
    mprio = 1'b0;
  endtask

  initial begin
    do_reset();
    // push then pop
    step(2'b01, 2'b00, 8'hA5, 8'h00);
    step(2'b01, 2'b01, 8'h00, 8'h00);
    idle(5);
    // underflow
    step(2'b01, 2'b01, 8'h00, 8'h00);
    idle(5);
    // LIFO across requesters
    step(2'b01, 2'b00, 8'h11, 8'h00);
    step(2'b10, 2'b00, 8'h00, 8'h22);
    step(2'b01, 2'b01, 8'h00, 8'h00);
    step(2'b10, 2'b11, 8'h00, 8'h00);
    idle(5);
    // contention from a fresh pointer
    do_reset();
    for (int i = 0; i < 6; i++)
      step(2'b11, 2'b00, 8'(8'h30 + i), 8'(8'h40 + i));
    idle(5);
    // overflow
    do_reset();
    for (int i = 1; i <= 15; i++)
      step(2'b01, 2'b00, 8'(i), 8'h00);
    step(2'b01, 2'b00, 8'hFF, 8'h00);
    idle(5);
    // reset with three pops in flight
    do_reset();
    for (int i = 0; i < 3; i++)
      step(2'b10, 2'b00, 8'h00, 8'(8'h50 + i));
    idle(5);
    for (int i = 0; i < 3; i++)
      step(2'b10, 2'b11, 8'h00, 8'h00);
    do_reset();
    idle(6);
    step(2'b11, 2'b11, 8'h00, 8'h00);
    idle(5);
    // randomized traffic, push-heavy then pop-heavy
    for (int ph = 0; ph < 4; ph++) begin
      int pct;
      pct = (ph % 2 == 0) ? 20 : 80;
      for (int i = 0; i < 150; i++) begin
        logic [1:0] v;
        logic [1:0] op;
        v     = 2'($urandom_range(0, 3));
        op[0] = $urandom_range(0, 99) < pct;
        op[1] = $urandom_range(0, 99) < pct;
        step(v, op, 8'($urandom_range(0, 255)),
             8'($urandom_range(0, 255)));
      end
    end
    idle(6);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/stack_arbiter.md
# stack_arbiter

Two-port arbiter and sequencer for the 8-bit, 16-entry LIFO stack block. It accepts push/pop requests from two independent requesters over valid/ready handshakes and grants one request per cycle using round-robin arbitration. It tracks stack occupancy so that it never overflows or underflows the stack, drives the stack's push/pop/data_in pins, and returns each result to the originating requester on a per-port response channel.

## Interface
Parameters:
- WIDTH, 8, data width; matches the stack.
- DEPTH, 15, maximum entries issued to the stack. The stack's pointer wraps on the 16th push, so 15 is the safe capacity.
- STK_LAT, 2, cycles from the cycle `stk_push`/`stk_pop` is high to the cycle the popped data is valid on `stk_data_out`.

Ports:
- clk  in  1  clock; all logic on rising edge.
- reset  in  1  synchronous, active-high. Must also reset the attached stack in the same cycle.
- req_valid  in  2  per-requester request valid; bit i belongs to requester i.
- req_op  in  2  per-requester opcode: 0 = push, 1 = pop.
- req_data  in  2*WIDTH  push data; requester i uses bits [i*WIDTH +: WIDTH].
- req_ready  out  2  grant; at most one bit high; combinational from `req_valid` and arbiter state.
- rsp_valid  out  2  one-cycle response strobe per requester; registered.
- rsp_data  out  WIDTH  popped data; 0 for push responses and error responses.
- rsp_err  out  1  qualifies `rsp_valid`: push-when-full or pop-when-empty.
- stk_push  out  1  registered push command to the stack.
- stk_pop  out  1  registered pop command to the stack.
- stk_data_in  out  WIDTH  registered push data to the stack.
- stk_data_out  in  WIDTH  stack read data.
- count  out  5  committed occupancy, 0..DEPTH.
- full  out  1  high when `count` == DEPTH.
- empty  out  1  high when `count` == 0.

## Operation
- **Arbitration**
  - Round-robin with a 1-bit priority pointer `prio`. Reset value is 0.
  - If only one requester is valid, grant it.
  - If both are valid, grant requester `prio`.
  - After any grant, `prio` becomes the index of the non-granted requester.
- **Acceptance:** a request is accepted in the cycle where `req_valid[i]` and `req_ready[i]` are both high. At most one request is accepted per cycle.
- **Accepted push**
  - If `count` < DEPTH: next cycle `stk_push`=1 and `stk_data_in`=data; `count` increments.
  - If `count` == DEPTH: no stack command is issued; the request completes with an error.
- **Accepted pop**
  - If `count` > 0: next cycle `stk_pop`=1; `count` decrements.
  - If `count` == 0: no stack command is issued; the request completes with an error.
- **Mutual exclusion:** `stk_push` and `stk_pop` are never high in the same cycle. Back-to-back commands of any mix are allowed every cycle.
- **Tag pipeline:** every accepted request, including errored ones, enters a tag pipeline of {valid, requester id, op, err}. The pipeline has STK_LAT+1 stages, so responses return in acceptance order.
- **Response**
  - At pipeline exit, `rsp_valid[id]`=1 for one cycle.
  - `rsp_data` = the `stk_data_out` sample for a good pop; otherwise 0.
  - `rsp_err` = err.
- **Count semantics:** `count` reflects granted operations (committed at acceptance), not stack completion. Same-cycle push and pop cannot occur because only one grant is made per cycle.
- **Reset values:**
  - `count`=0, `prio`=0, all tag stages invalid.
  - `stk_push`=0, `stk_pop`=0, `stk_data_in`=0.
  - `rsp_valid`=0, `rsp_data`=0, `rsp_err`=0.
  - `req_ready`=0 while `reset` is high.
- **Reset mid-operation:** in-flight requests are discarded with no responses. The stack is emptied concurrently.

## Timing
- **Request to response:** request accepted in cycle N, stack command high in cycle N+1, pop data valid on `stk_data_out` in cycle N+1+STK_LAT, response visible in cycle N+2+STK_LAT. With defaults: N+4.
- **Push latency:** push responses use the same latency as pops; errored requests also use it.
- **Throughput:** one request per cycle sustained.
- **Read-after-write:** a pop accepted in cycle N+1 after a push accepted in cycle N returns that push's data.
- **Occupancy flags:** `full`/`empty` update the cycle after acceptance. `req_ready` does not depend on `full`/`empty`; overflow and underflow are reported via `rsp_err`, never by stalling.

## Structure
- **Package `stack_arbiter_pkg`:**
  - OP_PUSH/OP_POP constants.
  - DEPTH and STK_LAT defaults.
  - The tag struct {valid, id, op, err}.
- **Sub-module `rr_arbiter2`:** two-input round-robin grant plus pointer. This is the only sub-module.
- The tag pipeline and occupancy counter are inline.

## Test plan
- **Push then pop:** reset; requester 0 pushes 0xA5 then pops → push response at N+4 with err=0; pop response `rsp_data`=0xA5 at N+5; `count` goes 0→1→0.
- **Contention:** both requesters request continuously for 6 cycles → grants alternate 0,1,0,1,0,1; `req_ready` is never 2'b11.
- **Overflow:** 15 pushes of 0x01..0x0F, then a 16th push of 0xFF → `full`=1; the 16th response has `rsp_err`=1; `stk_push` stays low for it; `count` remains 15.
- **Underflow:** pop after reset → `rsp_err`=1, `rsp_data`=0, `stk_pop` never asserted; `empty` stays 1.
- **LIFO order across requesters:** requester 0 pushes 0x11, requester 1 pushes 0x22, requester 0 pops, requester 1 pops, all back-to-back → responses 0x22 to requester 0 and 0x11 to requester 1, in order.
- **Reset mid-flight:** assert reset 2 cycles after three accepted pops → no `rsp_valid` is ever asserted for them; `count`=0 and `prio`=0 after reset.
